branch_target_buffer: RTL and testbench

Dynamic branch predictor for the 5-stage RISC-V core. It is the direct consumer of the EX-stage branch decision: it takes the resolved BranchJump together with the branch PC and target, and produces the misprediction and recovery signals used by NPC generation and the hazard unit. It also holds a direct-mapped BTB with 2-bit saturating counters, which the IF stage looks up combinationally to predict the next PC. Two 32-bit performance counters track resolved branches and mispredictions.

---
 rtl/branch_target_buffer_if.sv | 29 ++
 rtl/branch_target_buffer.sv | 64 ++++++
 tb/tb_branch_target_buffer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/branch_target_buffer_if.sv
// branch_target_buffer_if: IF lookup, EX resolution and statistics signals of the BTB
interface branch_target_buffer_if;
  logic [31:0] i_pc_if;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic [31:0] i_pc_ex;
  logic [2:0]  i_branch_type_e;
  logic        i_branch_jump;
  logic [31:0] i_branch_target;
  logic        i_pred_taken_e;
  logic [31:0] i_pred_target_e;
  logic        i_stall_e;
  logic        o_mispredict;
  logic [31:0] o_recover_pc;
  logic [31:0] o_branch_count;
  logic [31:0] o_miss_count;
  modport slave (
    input  i_pc_if, i_pc_ex, i_branch_type_e, i_branch_jump, i_branch_target,
           i_pred_taken_e, i_pred_target_e, i_stall_e,
    output o_pred_taken, o_pred_target, o_mispredict, o_recover_pc,
           o_branch_count, o_miss_count
  );
  modport master (
    output i_pc_if, i_pc_ex, i_branch_type_e, i_branch_jump, i_branch_target,
           i_pred_taken_e, i_pred_target_e, i_stall_e,
    input  o_pred_taken, o_pred_target, o_mispredict, o_recover_pc,
           o_branch_count, o_miss_count
  );
endinterface

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit counters, EX mispredict detection and branch statistics
module branch_target_buffer #(
  parameter int         ENTRY_BITS = 6,
  parameter logic [2:0] NOBRANCH   = 3'd0
) (
  input logic clk,
  input logic rst,
  branch_target_buffer_if.slave bus
);
  localparam int N  = 1 << ENTRY_BITS;
  localparam int TW = 30 - ENTRY_BITS;
  logic [N-1:0]          r_valid;
  logic [TW-1:0]         r_tag [N];
  logic [31:0]           r_target [N];
  logic [1:0]            r_ctr [N];
  logic [31:0]           r_branch_count, r_miss_count;
  logic [ENTRY_BITS-1:0] w_idx_if, w_idx_ex;
  logic [TW-1:0]         w_tag_if, w_tag_ex;
  logic [1:0]            w_ctr_ex;
  logic                  w_hit_if, w_hit_ex, w_br, w_upd, w_mp;
  assign w_idx_if = bus.i_pc_if[ENTRY_BITS+1:2];
  assign w_tag_if = bus.i_pc_if[31:ENTRY_BITS+2];
  assign w_idx_ex = bus.i_pc_ex[ENTRY_BITS+1:2];
  assign w_tag_ex = bus.i_pc_ex[31:ENTRY_BITS+2];
  assign w_hit_if = r_valid[w_idx_if] && (r_tag[w_idx_if] == w_tag_if);
  assign w_hit_ex = r_valid[w_idx_ex] && (r_tag[w_idx_ex] == w_tag_ex);
  assign w_ctr_ex = r_ctr[w_idx_ex];
  assign w_br     = bus.i_branch_type_e != NOBRANCH;
  assign w_upd    = w_br && !bus.i_stall_e;
  // a taken prediction with the wrong target is as costly as a wrong direction
  assign w_mp = w_br && ((bus.i_pred_taken_e != bus.i_branch_jump) ||
                (bus.i_pred_taken_e && bus.i_branch_jump && bus.i_pred_target_e != bus.i_branch_target));
  assign bus.o_pred_taken   = w_hit_if && r_ctr[w_idx_if][1];
  assign bus.o_pred_target  = bus.o_pred_taken ? r_target[w_idx_if] : bus.i_pc_if + 32'd4;
  assign bus.o_mispredict   = w_mp;
  assign bus.o_recover_pc   = bus.i_branch_jump ? bus.i_branch_target : bus.i_pc_ex + 32'd4;
  assign bus.o_branch_count = r_branch_count;
  assign bus.o_miss_count   = r_miss_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid        <= '0;
      r_branch_count <= '0;
      r_miss_count   <= '0;
      for (int i = 0; i < N; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (w_upd) begin
      r_branch_count <= r_branch_count + 32'd1;
      r_miss_count   <= r_miss_count + {31'd0, w_mp};
      if (w_hit_ex) begin
        r_ctr[w_idx_ex] <= bus.i_branch_jump ? (w_ctr_ex == 2'b11 ? 2'b11 : w_ctr_ex + 2'b01)
                                             : (w_ctr_ex == 2'b00 ? 2'b00 : w_ctr_ex - 2'b01);
        if (bus.i_branch_jump) r_target[w_idx_ex] <= bus.i_branch_target;
      end else if (bus.i_branch_jump) begin
        r_valid[w_idx_ex]  <= 1'b1;
        r_tag[w_idx_ex]    <= w_tag_ex;
        r_target[w_idx_ex] <= bus.i_branch_target;
        r_ctr[w_idx_ex]    <= 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed vector table, async-reset sequence and randomized model comparison
module tb_branch_target_buffer;
  localparam logic [31:0] NB = 32'd0;
  localparam logic [31:0] BQ = 32'd1;
  logic clk, rst;
  int checks = 0, failures = 0;
  branch_target_buffer_if bus();
  branch_target_buffer dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] pc_if, ty, pc_ex, bj, bt, pte, ptt, st;
    logic [31:0] xpt, xptg, xmp, xrpc, xbc, xmc;
  } vec_t;
  vec_t v [21];
  bit          m_valid [64];
  logic [31:0] m_tag [64];
  logic [31:0] m_tgt [64];
  int          m_ctr [64];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic apply(input logic [31:0] pc_if, ty, pc_ex, bj, bt, pte, ptt, st);
    bus.i_pc_if         = pc_if;
    bus.i_branch_type_e = ty[2:0];
    bus.i_pc_ex         = pc_ex;
    bus.i_branch_jump   = bj[0];
    bus.i_branch_target = bt;
    bus.i_pred_taken_e  = pte[0];
    bus.i_pred_target_e = ptt;
    bus.i_stall_e       = st[0];
  endtask
  task automatic chk_all(input logic [31:0] pt, ptg, mp, rpc, bc, mc);
    chk("pred_taken", {31'd0, bus.o_pred_taken}, pt);
    chk("pred_target", bus.o_pred_target, ptg);
    chk("mispredict", {31'd0, bus.o_mispredict}, mp);
    chk("recover_pc", bus.o_recover_pc, rpc);
    chk("branch_count", bus.o_branch_count, bc);
    chk("miss_count", bus.o_miss_count, mc);
  endtask
  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction
  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && m_tag[m_idx(pc)] == pc / 256;
  endfunction
  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && m_ctr[m_idx(pc)] >= 2;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
    end
  endtask
  task automatic do_reset();
    apply(0, NB, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    logic [31:0] bc, mc, pc_if, pc_ex, bt, ty, bj, pte, ptt, st, emp;
    int k;
    v[0]  = '{'h100, NB, 0, 0, 0, 0, 0, 0, 0, 'h104, 0, 'h4, 0, 0};
    v[1]  = '{'h100, BQ, 'h100, 1, 'h80, 0, 0, 0, 0, 'h104, 1, 'h80, 0, 0};
    v[2]  = '{'h100, NB, 0, 0, 0, 0, 0, 0, 1, 'h80, 0, 'h4, 1, 1};
    v[3]  = '{'h100, BQ, 'h100, 0, 'h80, 1, 'h80, 0, 1, 'h80, 1, 'h104, 1, 1};
    v[4]  = '{'h100, BQ, 'h100, 0, 'h80, 0, 0, 0, 0, 'h104, 0, 'h104, 2, 2};
    v[5]  = '{'h100, BQ, 'h100, 0, 'h80, 0, 0, 0, 0, 'h104, 0, 'h104, 3, 2};
    v[6]  = '{'h100, BQ, 'h100, 1, 'h80, 0, 0, 0, 0, 'h104, 1, 'h80, 4, 2};
    v[7]  = '{'h100, BQ, 'h100, 1, 'h80, 0, 0, 0, 0, 'h104, 1, 'h80, 5, 3};
    v[8]  = '{'h100, NB, 0, 0, 0, 0, 0, 0, 1, 'h80, 0, 'h4, 6, 4};
    v[9]  = '{'h200, NB, 0, 0, 0, 0, 0, 0, 0, 'h204, 0, 'h4, 6, 4};
    v[10] = '{'h200, BQ, 'h200, 1, 'h300, 0, 0, 0, 0, 'h204, 1, 'h300, 6, 4};
    v[11] = '{'h100, NB, 0, 0, 0, 0, 0, 0, 0, 'h104, 0, 'h4, 7, 5};
    v[12] = '{'h200, NB, 0, 0, 0, 0, 0, 0, 1, 'h300, 0, 'h4, 7, 5};
    v[13] = '{'h200, BQ, 'h200, 1, 'h400, 1, 'h300, 1, 1, 'h300, 1, 'h400, 7, 5};
    v[14] = '{'h200, NB, 0, 0, 0, 0, 0, 0, 1, 'h300, 0, 'h4, 7, 5};
    v[15] = '{'h200, BQ, 'h200, 1, 'h300, 1, 'h300, 0, 1, 'h300, 0, 'h300, 7, 5};
    v[16] = '{'h200, BQ, 'h200, 1, 'h300, 1, 'h300, 0, 1, 'h300, 0, 'h300, 8, 5};
    v[17] = '{'h200, BQ, 'h200, 1, 'h300, 1, 'h300, 0, 1, 'h300, 0, 'h300, 9, 5};
    v[18] = '{'h200, BQ, 'h200, 0, 'h300, 1, 'h300, 0, 1, 'h300, 1, 'h204, 10, 5};
    v[19] = '{'h200, NB, 0, 0, 0, 0, 0, 0, 1, 'h300, 0, 'h4, 11, 6};
    v[20] = '{'h104, NB, 0, 0, 0, 0, 0, 0, 0, 'h108, 0, 'h4, 11, 6};
    do_reset();
    for (int i = 0; i < 21; i++) begin
      apply(v[i].pc_if, v[i].ty, v[i].pc_ex, v[i].bj, v[i].bt, v[i].pte, v[i].ptt, v[i].st);
      #2;
      chk_all(v[i].xpt, v[i].xptg, v[i].xmp, v[i].xrpc, v[i].xbc, v[i].xmc);
      @(posedge clk);
      #1;
    end
    // reset between edges while a taken update is pending
    apply('h200, BQ, 'h104, 1, 'h500, 0, 0, 0);
    #2;
    chk("pre_reset_hit", {31'd0, bus.o_pred_taken}, 1);
    rst = 1'b1;
    #1;
    chk("async_pred_taken", {31'd0, bus.o_pred_taken}, 0);
    chk("async_pred_target", bus.o_pred_target, 'h204);
    chk("async_branch_count", bus.o_branch_count, 0);
    chk("async_miss_count", bus.o_miss_count, 0);
    @(posedge clk);
    #1;
    bus.i_pc_if = 'h104;
    #1;
    chk("rst_hold_no_alloc", {31'd0, bus.o_pred_taken}, 0);
    chk("rst_hold_count", bus.o_branch_count, 0);
    apply('h104, NB, 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_target", bus.o_pred_target, 'h108);
    chk("post_reset_count", bus.o_branch_count, 0);
    m_reset();
    bc = 0;
    mc = 0;
    for (int n = 0; n < 400; n++) begin
      pc_if = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2);
      pc_ex = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2);
      bt    = 32'h1000 * $urandom_range(1, 3);
      ty    = ($urandom_range(0, 3) == 0) ? NB : 32'($urandom_range(1, 6));
      bj    = 32'($urandom_range(0, 1));
      st    = ($urandom_range(0, 4) == 0) ? 1 : 0;
      pte   = {31'd0, m_taken(pc_ex)};
      ptt   = pte[0] ? m_tgt[m_idx(pc_ex)] : pc_ex + 4;
      if ($urandom_range(0, 3) == 0) begin
        pte = 32'($urandom_range(0, 1));
        ptt = 32'h1000 * $urandom_range(1, 3);
      end
      apply(pc_if, ty, pc_ex, bj, bt, pte, ptt, st);
      #2;
      emp = (ty != NB && (pte != bj || (pte == 1 && bj == 1 && ptt != bt))) ? 1 : 0;
      chk_all({31'd0, m_taken(pc_if)}, m_taken(pc_if) ? m_tgt[m_idx(pc_if)] : pc_if + 4, emp,
              bj == 1 ? bt : pc_ex + 4, bc, mc);
      @(posedge clk);
      #1;
      if (ty != NB && st == 0) begin
        bc++;
        mc += emp;
        k = m_idx(pc_ex);
        if (m_hit(pc_ex)) begin
          if (bj == 1) begin
            m_ctr[k] = (m_ctr[k] < 3) ? m_ctr[k] + 1 : 3;
            m_tgt[k] = bt;
          end else begin
            m_ctr[k] = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
          end
        end else if (bj == 1) begin
          m_valid[k] = 1;
          m_tag[k]   = pc_ex / 256;
          m_tgt[k]   = bt;
          m_ctr[k]   = 2;
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
